e_ppn_mod_add_sub_ctrl: RTL and testbench
=========================================

Name: e_ppn_mod_add_sub_ctrl

Overview:
- Initiator side of the add/sub handshake: sequences the shared 257-bit add/sub unit to compute r = (x + y) mod p or r = (x − y) mod p.
- Sits between the Kaliski inverse datapath/FSM and the add/sub unit: drives start, operands and select, then consumes sum and carry.
- Always runs two add/sub passes (raw op, then a ±p correction) so latency is constant and independent of the data, as required for constant-time inversion.

Parameters:
N, 257, adder width (operand width + 1)
ADD_LAT, 1, cycles from operands driven to as_s/as_c valid at the add/sub unit output; must be ≥1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
op  in  1  0 = modular add, 1 = modular subtract
x_i  in  N-1  operand x, precondition x < p
y_i  in  N-1  operand y, precondition y < p
p_i  in  N-1  modulus p, odd, nonzero
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
r_o  out  N-1  result; held until the next accepted start
as_start  out  1  start_add_sub to the add/sub unit
as_a  out  N  operand a to the add/sub unit
as_b  out  N  operand b to the add/sub unit
as_sel  out  1  0 = a+b, 1 = a−b (carry-in = sel, b inverted)
as_done  in  1  done_add from the add/sub unit
as_c  in  1  carry out from the add/sub unit (subtract: 1 = no borrow)
as_s  in  N  sum from the add/sub unit

Behaviour:
- Reset (async, active-low): state = IDLE; busy, done, as_start, as_sel = 0; as_a, as_b, r_o = 0; internal registers cleared. Reset mid-operation aborts with no done pulse.
- On start=1 in IDLE: latch op, x, y, p (zero-extended to N bits) and go to OP1. start is ignored while busy and during the DONE cycle.
- OP1, ADD_LAT+1 cycles:
  - as_start = 1; as_a = {0,x}; as_b = {0,y}; as_sel = op.
  - On the edge ending the last cycle, require as_done = 1 and capture s1 = as_s, c1 = as_c.
- OP2, ADD_LAT+1 cycles, as_start = 1, as_a = s1:
  - Add (op=0): as_b = {0,p}, as_sel = 1; capture s2, c2. r = c2 ? s2[N-2:0] : s1[N-2:0], so the correction applies iff s1 ≥ p.
  - Sub (op=1): as_b = {0,p}, as_sel = 0; capture s2. r = c1 ? s1[N-2:0] : s2[N-2:0], so the correction applies iff x < y. The wrap of s1 + p past 2^N is intentional; only the low N-1 bits are used.
- DONE, 1 cycle: done = 1; r_o loaded on entry; busy = 0; next state IDLE.
- as_start = 0 and as_sel = 0 in IDLE/DONE; as_a/as_b hold their last values.
- If as_done = 0 at a capture edge, the phase extends one cycle at a time until as_done = 1 (stall tolerance).
- Latency: counting the start-sample edge as cycle 0, done is high in cycle 2·ADD_LAT+3 (cycle 5 when ADD_LAT=1).
- Operand changes on x_i/y_i/p_i/op after acceptance have no effect.
- Edge cases: x = y with op=1 gives 0; x + y = p gives 0; x + y = 2p−2 gives p−2.

Test Plan:
- p=13, op=0, x=10, y=7 → done in cycle 5, r_o=4, busy high in cycles 1–4, done high for exactly 1 cycle.
- p=13, op=0, x=2, y=3 → r_o=5, OP2 still executes, latency unchanged (5 cycles).
- p=13, op=1, x=3, y=5 → c1=0, r_o=11; op=1, x=7, y=7 → r_o=0.
- p=2^255−19, op=0, x=y=p−1 → r_o=p−2; op=1, x=0, y=1 → r_o=p−1.
- start re-pulsed in cycle 2 with different operands → ignored; first result returned; reset_n low in cycle 3 → all outputs 0, no done, IDLE.
- ADD_LAT=3 with as_done held low for 2 extra cycles in OP1 → done delayed by exactly 2 cycles (cycle 11), r_o still correct.

Source files
------------

// File: rtl/e_ppn_mod_add_sub_ctrl.sv
// e_ppn_mod_add_sub_ctrl: constant-time modular add/sub sequencer driving a shared add/sub unit
module e_ppn_mod_add_sub_ctrl #(
    parameter int N       = 257,
    parameter int ADD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-2:0] x_i,
    input  logic [N-2:0] y_i,
    input  logic [N-2:0] p_i,
    output logic         busy,
    output logic         done,
    output logic [N-2:0] r_o,
    output logic         as_start,
    output logic [N-1:0] as_a,
    output logic [N-1:0] as_b,
    output logic         as_sel,
    input  logic         as_done,
    input  logic         as_c,
    input  logic [N-1:0] as_s
);
    localparam int CW = $clog2(ADD_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, OP1, OP2, FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d, c1_q, c1_d;
    logic [N-2:0]  p_q, p_d, r_q, r_d;
    logic [N-1:0]  s1_q, s1_d, a_q, a_d, b_q, b_d;
    logic          last, cap;

    assign last     = cnt_q == CW'(ADD_LAT);
    assign cap      = last && as_done;
    assign busy     = state_q == OP1 || state_q == OP2;
    assign done     = state_q == FIN;
    assign as_start = busy;
    assign as_sel   = state_q == OP1 ? op_q : state_q == OP2 ? ~op_q : 1'b0;
    assign as_a     = a_q;
    assign as_b     = b_q;
    assign r_o      = r_q;

    // Next state: both passes always run; a phase stretches while the unit stalls
    always_comb begin
        state_d = state_q;
        cnt_d   = last ? cnt_q : cnt_q + CW'(1);
        op_d    = op_q;
        c1_d    = c1_q;
        p_d     = p_q;
        r_d     = r_q;
        s1_d    = s1_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    op_d    = op;
                    p_d     = p_i;
                    a_d     = {1'b0, x_i};
                    b_d     = {1'b0, y_i};
                    state_d = OP1;
                end
            end
            OP1: if (cap) begin
                s1_d    = as_s;
                c1_d    = as_c;
                a_d     = as_s;
                b_d     = {1'b0, p_q};
                cnt_d   = '0;
                state_d = OP2;
            end
            OP2: if (cap) begin
                r_d     = op_q ? (c1_q ? s1_q[N-2:0] : as_s[N-2:0])
                               : (as_c ? as_s[N-2:0] : s1_q[N-2:0]);
                cnt_d   = '0;
                state_d = FIN;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            c1_q    <= 1'b0;
            p_q     <= '0;
            r_q     <= '0;
            s1_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            c1_q    <= c1_d;
            p_q     <= p_d;
            r_q     <= r_d;
            s1_q    <= s1_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
endmodule

// File: tb/tb_e_ppn_mod_add_sub_ctrl.sv
// tb_e_ppn_mod_add_sub_ctrl: randomized check of the modular add/sub sequencer against a modular-arithmetic model
module tb_e_ppn_mod_add_sub_ctrl;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start [2];
    logic         stall [2];
    logic         op;
    logic [255:0] x_in, y_in, p_in;
    logic         busy [2], done [2], as_start [2], as_sel [2], as_done [2], as_c [2];
    logic [255:0] r_o [2];
    logic [256:0] as_a [2], as_b [2], as_s [2];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] p25519;

    always #5 clk = ~clk;

    // Instance 0 has a one-cycle add/sub unit, instance 1 a three-cycle one
    for (genvar g = 0; g < 2; g++) begin : g_dut
        e_ppn_mod_add_sub_ctrl #(.N(257), .ADD_LAT(g == 0 ? 1 : 3)) dut (
            .clk(clk), .reset_n(reset_n), .start(start[g]), .op(op),
            .x_i(x_in), .y_i(y_in), .p_i(p_in),
            .busy(busy[g]), .done(done[g]), .r_o(r_o[g]),
            .as_start(as_start[g]), .as_a(as_a[g]), .as_b(as_b[g]), .as_sel(as_sel[g]),
            .as_done(as_done[g]), .as_c(as_c[g]), .as_s(as_s[g])
        );
        assign {as_c[g], as_s[g]} = as_sel[g] ? {1'b0, as_a[g]} + {1'b0, ~as_b[g]} + 258'd1
                                              : {1'b0, as_a[g]} + {1'b0, as_b[g]};
        assign as_done[g] = as_start[g] & ~stall[g];
    end

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mref(input logic o, input logic [255:0] x, y, p);
        logic [257:0] t;
        if (!o) begin
            t = 258'(x) + 258'(y);
            if (t >= 258'(p)) t = t - 258'(p);
        end else begin
            t = x >= y ? 258'(x - y) : 258'(x) + 258'(p) - 258'(y);
        end
        return t[255:0];
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_zero(input int k);
        chk("rst_busy", busy[k], 0);
        chk("rst_done", done[k], 0);
        chk("rst_as_start", as_start[k], 0);
        chk("rst_as_sel", as_sel[k], 0);
        chk("rst_as_a", as_a[k], 0);
        chk("rst_as_b", as_b[k], 0);
        chk("rst_r", r_o[k], 0);
    endtask

    task automatic run(input int k, input logic o, input logic [255:0] x, y, p, input int st, input bit rp);
        int lat = k == 0 ? 1 : 3;
        int cyc;
        logic [255:0] e = mref(o, x, y, p);
        @(negedge clk);
        op = o; x_in = x; y_in = y; p_in = p;
        stall[k] = st > 0;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        op = ~o; x_in = rnd(); y_in = rnd(); p_in = rnd();
        cyc = 1;
        while (!done[k] && cyc < 40) begin
            chk("busy", busy[k], 1);
            if (cyc >= lat + 1 + st) stall[k] = 1'b0;
            start[k] = rp && cyc == 2;
            @(negedge clk);
            cyc++;
        end
        start[k] = 1'b0;
        stall[k] = 1'b0;
        chk("latency", cyc, 2 * lat + 3 + st);
        chk("done", done[k], 1);
        chk("result", r_o[k], e);
        chk("busy_at_done", busy[k], 0);
        @(negedge clk);
        chk("done_pulse", done[k], 0);
        chk("result_hold", r_o[k], e);
    endtask

    initial begin
        start = '{1'b0, 1'b0};
        stall = '{1'b0, 1'b0};
        op = 1'b0; x_in = '0; y_in = '0; p_in = '0;
        p25519 = '1;
        p25519[255] = 1'b0;
        p25519 = p25519 - 256'd18;
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        reset_n = 1'b1;
        run(0, 0, 10, 7, 13, 0, 0);
        run(0, 0, 2, 3, 13, 0, 0);
        run(0, 1, 3, 5, 13, 0, 0);
        run(0, 1, 7, 7, 13, 0, 0);
        run(0, 0, 6, 7, 13, 0, 0);
        run(0, 0, 12, 12, 13, 0, 0);
        run(0, 0, p25519 - 1, p25519 - 1, p25519, 0, 0);
        run(0, 1, 0, 1, p25519, 0, 0);
        run(0, 0, 9, 8, 13, 0, 1);
        run(1, 0, 10, 7, 13, 2, 0);
        run(1, 1, 3, 5, 13, 0, 0);
        @(negedge clk);
        op = 1'b0; x_in = 10; y_in = 7; p_in = 13;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_zero(0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", done[0], 0);
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", done[0], 0);
            chk("post_rst_busy", busy[0], 0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [255:0] p, x, y;
            p = (i % 3 == 0) ? 256'($urandom_range(1000, 3)) : rnd();
            p[0] = 1'b1;
            if (i % 5 == 0) p = p25519;
            x = rnd() % p;
            y = (i % 7 == 0) ? x : rnd() % p;
            run(i % 2, 1'($urandom_range(1, 0)), x, y, p, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
